// File: rtl/charge_pkg.sv
// Shared types and helpers for the charge bay scheduler.
package charge_pkg;

    localparam int unsigned DEF_NUM_BAYS = 4;
    localparam int unsigned DEF_TIME_W   = 8;
    localparam int unsigned DEF_BAY_W    = $clog2(DEF_NUM_BAYS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        GRANT  = 2'd2
    } state_t;

    // Add two credits and clamp at max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/charge_tick_prescaler.sv
// Divides CLK down to one tick every TICK_DIV cycles while enabled; clr restarts the count.
module charge_tick_prescaler #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/charge_bay_scheduler.sv
// Round-robin, break-before-make time slicing of one charging supply across NUM_BAYS bays.
// Optional served-session counter enabled by defining CHARGE_SCHED_STATS_EN.
module charge_bay_scheduler
    import charge_pkg::*;
#(
    parameter  int unsigned NUM_BAYS = DEF_NUM_BAYS,
    parameter  int unsigned TIME_W   = DEF_TIME_W,
    parameter  int unsigned TICK_DIV = 50,
    parameter  int unsigned SLICE    = 4,
    localparam int unsigned BAY_W    = $clog2(NUM_BAYS)
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                load_valid,
    input  logic [BAY_W-1:0]    load_bay,
    input  logic [TIME_W-1:0]   load_time,
    output logic                load_ready,
    input  logic                cancel,
    input  logic [BAY_W-1:0]    cancel_bay,
    output logic [NUM_BAYS-1:0] power_en,
    output logic [BAY_W-1:0]    active_bay,
    output logic [TIME_W-1:0]   restime,
    output logic [NUM_BAYS-1:0] bay_busy,
    output logic                done_pulse,
    output logic [BAY_W-1:0]    done_bay
`ifdef CHARGE_SCHED_STATS_EN
    ,
    output logic [15:0]         served_cnt
`endif
);

    localparam int unsigned SLICE_W = $clog2(SLICE + 1);
    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    state_t                state, state_nxt;
    logic [TIME_W-1:0]     remain     [NUM_BAYS];
    logic [TIME_W-1:0]     remain_nxt [NUM_BAYS];
    logic [NUM_BAYS-1:0]   busy_nxt;
    logic [NUM_BAYS-1:0]   others_busy;
    logic [TIME_W-1:0]     nv;
    logic [BAY_W-1:0]      rr, rr_nxt;
    logic [BAY_W-1:0]      active_nxt;
    logic [BAY_W-1:0]      done_bay_nxt;
    logic                  done_nxt;
    logic [SLICE_W-1:0]    slice_cnt, slice_nxt, slice_inc;
    logic                  tick;
    logic                  in_grant;

    // First busy bay after rr, wrapping; rr itself is considered last.
    function automatic logic [BAY_W-1:0] next_busy(input logic [NUM_BAYS-1:0] busy,
                                                   input logic [BAY_W-1:0]    from);
        logic [BAY_W-1:0] pick;
        int unsigned      idx;
        pick = from;
        for (int i = int'(NUM_BAYS); i >= 1; i--) begin
            idx = (int'(from) + i) % NUM_BAYS;
            if (busy[BAY_W'(idx)]) pick = BAY_W'(idx);
        end
        return pick;
    endfunction

    assign in_grant = (state == GRANT);

    charge_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (!in_grant),
        .en    (in_grant),
        .tick  (tick)
    );

    // Credit update: countdown, then saturating load, then cancel overrides everything.
    always_comb begin
        busy_nxt = '0;
        nv       = '0;
        for (int i = 0; i < int'(NUM_BAYS); i++) begin
            nv = remain[i];
            if (in_grant && tick && (active_bay == BAY_W'(i)) && (remain[i] != '0))
                nv = remain[i] - TIME_W'(1);
            if (load_valid && load_ready && (load_bay == BAY_W'(i)))
                nv = TIME_W'(sat_add(32'(nv), 32'(load_time), 32'(TIME_MAX)));
            if (cancel && (cancel_bay == BAY_W'(i)))
                nv = '0;
            remain_nxt[i] = nv;
            busy_nxt[i]   = (nv != '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr;
        active_nxt   = active_bay;
        slice_nxt    = slice_cnt;
        done_nxt     = 1'b0;
        done_bay_nxt = done_bay;
        slice_inc    = slice_cnt + SLICE_W'(1);
        others_busy  = busy_nxt & ~(NUM_BAYS'(1) << active_bay);
        case (state)
            IDLE: begin
                if (|bay_busy) state_nxt = SWITCH;
            end
            SWITCH: begin
                if (|busy_nxt) begin
                    active_nxt = next_busy(busy_nxt, rr);
                    slice_nxt  = '0;
                    state_nxt  = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (cancel && (cancel_bay == active_bay)) begin
                    rr_nxt    = active_bay;
                    state_nxt = (|busy_nxt) ? SWITCH : IDLE;
                end else if (tick) begin
                    if (remain_nxt[active_bay] == '0) begin
                        done_nxt     = 1'b1;
                        done_bay_nxt = active_bay;
                        rr_nxt       = active_bay;
                        state_nxt    = (|busy_nxt) ? SWITCH : IDLE;
                    end else if (slice_inc == SLICE_W'(SLICE)) begin
                        slice_nxt = '0;
                        if (|others_busy) begin
                            rr_nxt    = active_bay;
                            state_nxt = SWITCH;
                        end
                    end else begin
                        slice_nxt = slice_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs follow the next state so power_en lines up with GRANT.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < int'(NUM_BAYS); i++) remain[i] <= '0;
            rr         <= BAY_W'(NUM_BAYS - 1);
            slice_cnt  <= '0;
            active_bay <= '0;
            power_en   <= '0;
            restime    <= '0;
            bay_busy   <= '0;
            done_pulse <= 1'b0;
            done_bay   <= '0;
            load_ready <= 1'b1;
        end else begin
            for (int i = 0; i < int'(NUM_BAYS); i++) remain[i] <= remain_nxt[i];
            rr         <= rr_nxt;
            slice_cnt  <= slice_nxt;
            active_bay <= active_nxt;
            power_en   <= (state_nxt == GRANT) ? (NUM_BAYS'(1) << active_nxt) : '0;
            restime    <= (state_nxt == GRANT) ? remain_nxt[active_nxt] : '0;
            bay_busy   <= busy_nxt;
            done_pulse <= done_nxt;
            done_bay   <= done_bay_nxt;
            load_ready <= (state_nxt != SWITCH);
        end
    end

`ifdef CHARGE_SCHED_STATS_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)                               served_cnt <= '0;
        else if (done_nxt && served_cnt != '1)    served_cnt <= served_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_charge_bay_scheduler.sv
// Scoreboard bench for charge_bay_scheduler: expected grants/completions queued by stimulus, checked by a monitor.
module tb_charge_bay_scheduler;

    localparam int unsigned NUM_BAYS = 4;
    localparam int unsigned TIME_W   = 8;
    localparam int unsigned BAY_W    = 2;

    logic                CLK = 1'b0;
    logic                RST_n = 1'b0;
    logic                load_valid = 1'b0;
    logic [BAY_W-1:0]    load_bay = '0;
    logic [TIME_W-1:0]   load_time = '0;
    logic                load_ready;
    logic                cancel = 1'b0;
    logic [BAY_W-1:0]    cancel_bay = '0;
    logic [NUM_BAYS-1:0] power_en;
    logic [BAY_W-1:0]    active_bay;
    logic [TIME_W-1:0]   restime;
    logic [NUM_BAYS-1:0] bay_busy;
    logic                done_pulse;
    logic [BAY_W-1:0]    done_bay;
`ifdef CHARGE_SCHED_STATS_EN
    logic [15:0]         served_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [NUM_BAYS-1:0] grant_q[$];
    logic [BAY_W-1:0]    done_q[$];
    logic [NUM_BAYS-1:0] prev_pe = '0;

    charge_bay_scheduler #(
        .NUM_BAYS (NUM_BAYS),
        .TIME_W   (TIME_W),
        .TICK_DIV (4),
        .SLICE    (2)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .load_valid (load_valid),
        .load_bay   (load_bay),
        .load_time  (load_time),
        .load_ready (load_ready),
        .cancel     (cancel),
        .cancel_bay (cancel_bay),
        .power_en   (power_en),
        .active_bay (active_bay),
        .restime    (restime),
        .bay_busy   (bay_busy),
        .done_pulse (done_pulse),
        .done_bay   (done_bay)
`ifdef CHARGE_SCHED_STATS_EN
        ,
        .served_cnt (served_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [BAY_W-1:0] bay, input logic [TIME_W-1:0] t);
        load_valid = 1'b1;
        load_bay   = bay;
        load_time  = t;
        step();
        load_valid = 1'b0;
    endtask

    task automatic wait_pe(input logic [NUM_BAYS-1:0] v, input int budget, input string name);
        int k;
        k = 0;
        while (power_en !== v && k < budget) begin
            step();
            k++;
        end
        check(name, power_en, v);
    endtask

    // Monitor: pops expectations on grant rising and done_pulse; checks grant invariants every cycle.
    always @(negedge CLK) begin
        if (RST_n) begin
            check("onehot0", $onehot0(power_en), 1);
            if (prev_pe != '0 && power_en != '0 && prev_pe != power_en) begin
                n_tests++;
                n_fail++;
                $display("FAIL bbm: got %b after %b expected a zero cycle", power_en, prev_pe);
            end
            if (power_en != '0 && prev_pe == '0) begin
                if (grant_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL grant: got %b expected no grant", power_en);
                end else begin
                    check("grant", power_en, grant_q.pop_front());
                end
            end
            if (done_pulse) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done: got done_bay %0d expected no done_pulse", done_bay);
                end else begin
                    check("done_bay", done_bay, done_q.pop_front());
                end
            end
            prev_pe = power_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a load pending
        load_valid = 1'b1; load_bay = 2'd1; load_time = 8'd9;
        step(3);
        check("rst_power_en", power_en, 0);
        check("rst_restime", restime, 0);
        check("rst_bay_busy", bay_busy, 0);
        check("rst_done", {done_pulse, done_bay, active_bay}, 0);
        check("rst_ready", load_ready, 1);
        load_valid = 1'b0;
        RST_n = 1'b1;
        step(3);
        check("idle_power_en", power_en, 0);
        check("idle_busy", bay_busy, 0);

        // Single bay, 3 units
        grant_q.push_back(4'b0100);
        done_q.push_back(2'd2);
        do_load(2'd2, 8'd3);
        check("s1_e0_pe", power_en, 0);
        check("s1_e0_busy", bay_busy, 4'b0100);
        step();
        check("s1_switch_ready", load_ready, 0);
        check("s1_switch_pe", power_en, 0);
        step();
        check("s1_grant_pe", power_en, 4'b0100);
        check("s1_rt3", restime, 3);
        check("s1_active", active_bay, 2);
        step(4);
        check("s1_rt2", restime, 2);
        step(4);
        check("s1_rt1", restime, 1);
        step(4);
        check("s1_done", done_pulse, 1);
        check("s1_done_bay", done_bay, 2);
        check("s1_pe_off", power_en, 0);
        check("s1_rt0", restime, 0);
        step();
        check("s1_done_clr", done_pulse, 0);
        check("s1_idle_busy", bay_busy, 0);

        // Two bays alternate in slices of 2 units
        grant_q.push_back(4'b0001); grant_q.push_back(4'b0010);
        grant_q.push_back(4'b0001); grant_q.push_back(4'b0010);
        grant_q.push_back(4'b0001); grant_q.push_back(4'b0010);
        done_q.push_back(2'd0); done_q.push_back(2'd1);
        do_load(2'd0, 8'd5);
        do_load(2'd1, 8'd5);
        for (int k = 0; k < 300 && !(done_q.size() == 0 && power_en == '0); k++) step();
        check("s2_done_left", done_q.size(), 0);
        check("s2_grant_left", grant_q.size(), 0);
        step(2);

        // Saturation and tick+load on the active bay
        grant_q.push_back(4'b1000);
        do_load(2'd3, 8'd250);
        do_load(2'd3, 8'd10);
        step();
        check("s3_pe", power_en, 4'b1000);
        check("s3_sat", restime, 255);
        step(3);
        do_load(2'd3, 8'd1);
        check("s3_tick_load", restime, 255);
        step(4);
        check("s3_tick", restime, 254);

        // Cancel the active bay while bay3 waits
        grant_q.push_back(4'b0010);
        grant_q.push_back(4'b1000);
        do_load(2'd1, 8'd20);
        wait_pe(4'b0010, 100, "s4_bay1_grant");
        cancel = 1'b1; cancel_bay = 2'd1;
        step();
        cancel = 1'b0;
        check("s4_cancel_pe", power_en, 0);
        check("s4_cancel_done", done_pulse, 0);
        check("s4_cancel_busy", bay_busy, 4'b1000);
        step();
        check("s4_regrant", power_en, 4'b1000);

        // Cancel and load to the same bay: cancel wins
        cancel = 1'b1; cancel_bay = 2'd0;
        load_valid = 1'b1; load_bay = 2'd0; load_time = 8'd7;
        step();
        cancel = 1'b0; load_valid = 1'b0;
        check("s5_busy", bay_busy, 4'b1000);
        step(3);
        check("s5_busy_hold", bay_busy, 4'b1000);
        check("s5_pe", power_en, 4'b1000);

        // Cancel the last busy bay: back to idle without a completion
        cancel = 1'b1; cancel_bay = 2'd3;
        step();
        cancel = 1'b0;
        check("s6_pe", power_en, 0);
        check("s6_busy", bay_busy, 0);
        check("s6_done", done_pulse, 0);
        step(3);
        check("s6_idle_pe", power_en, 0);
        check("s6_ready", load_ready, 1);

`ifdef CHARGE_SCHED_STATS_EN
        check("served_cnt", served_cnt, 3);
`endif
        check("end_grant_q", grant_q.size(), 0);
        check("end_done_q", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
